// File: rtl/hyperbus_if.sv
// HyperBus pin bundle between the SoC controller (master) and a device model (slave).
interface hyperbus_if;
   logic       cs_ni;
   logic [7:0] dq_i;
   logic [7:0] dq_o;
   logic       dq_oe_o;
   logic       rwds_i;
   logic       rwds_o;
   logic       rwds_oe_o;

   modport master (
      output cs_ni, dq_i, rwds_i,
      input  dq_o, dq_oe_o, rwds_o, rwds_oe_o
   );

   modport slave (
      input  cs_ni, dq_i, rwds_i,
      output dq_o, dq_oe_o, rwds_o, rwds_oe_o
   );
endinterface

// File: rtl/hyperbus_dev_model.sv
// Single-chip HyperBus device responder: CA decode, initial latency, SDR memory
// reads/writes from a word array, CR0 register writes and a transaction counter.
module hyperbus_dev_model #(
   parameter int unsigned MemWords      = 4096,
   parameter int unsigned LatencyCycles = 6,
   parameter int unsigned DoubleLatency = 1,
   parameter logic [15:0] IdReg         = 16'h0c81,
   parameter logic [15:0] Cr0Reset      = 16'h8f1f
) (
   input  logic        clk_i,
   input  logic        rst_i,
   hyperbus_if.slave   bus,
   output logic [15:0] cr0_o,
   output logic [15:0] txn_cnt_o
);

   localparam int unsigned AddrW = $clog2(MemWords);
   localparam int unsigned Lat   = LatencyCycles * ((DoubleLatency != 0) ? 2 : 1);
   localparam int unsigned CntW  = 8;

   typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WRITE, S_READ, S_REGW} state_e;

   state_e             state_q, state_d;
   logic [39:0]        ca_q;
   logic [47:0]        ca_w;
   logic [CntW-1:0]    cnt_q;
   logic [AddrW-1:0]   addr_q, addr_nxt;
   logic               is_rd_q, is_reg_q, lin_q, hi_q, xfer_q;
   logic [7:0]         cr0_hi_q;
   logic [15:0]        cr0_q, txn_q, rd_word;
   logic [15:0]        mem [MemWords];
   logic               ca_unused;

   // Full CA word in the cycle its last byte is on the bus.
   assign ca_w      = {ca_q, bus.dq_i};
   assign ca_unused = ^{ca_w[44:16+AddrW-3], ca_w[15:3]};
   assign addr_nxt  = lin_q ? addr_q + AddrW'(1) : {addr_q[AddrW-1:4], addr_q[3:0] + 4'd1};
   assign rd_word   = is_reg_q ? IdReg : mem[addr_q];
   assign cr0_o     = cr0_q;
   assign txn_cnt_o = txn_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state plus pin drivers; every enable is gated by an asserted chip select.
   always_comb begin
      state_d       = state_q;
      bus.dq_o      = 8'h00;
      bus.dq_oe_o   = 1'b0;
      bus.rwds_o    = 1'b0;
      bus.rwds_oe_o = 1'b0;
      if (bus.cs_ni) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_CA;
            S_CA: begin
               bus.rwds_oe_o = 1'b1;
               bus.rwds_o    = (DoubleLatency != 0);
               if (cnt_q == CntW'(5)) state_d = (!ca_w[47] && ca_w[46]) ? S_REGW : S_LAT;
            end
            S_LAT: if (cnt_q == CntW'(0)) state_d = is_rd_q ? S_READ : S_WRITE;
            S_READ: begin
               bus.dq_oe_o   = 1'b1;
               bus.rwds_oe_o = 1'b1;
               bus.rwds_o    = hi_q;
               bus.dq_o      = hi_q ? rd_word[15:8] : rd_word[7:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ca_q     <= 40'h0;
         cnt_q    <= CntW'(0);
         addr_q   <= AddrW'(0);
         is_rd_q  <= 1'b0;
         is_reg_q <= 1'b0;
         lin_q    <= 1'b0;
         hi_q     <= 1'b1;
         xfer_q   <= 1'b0;
         cr0_hi_q <= 8'h00;
         cr0_q    <= Cr0Reset;
         txn_q    <= 16'h0000;
      end else if (bus.cs_ni) begin
         if (state_q != S_IDLE && xfer_q) txn_q <= txn_q + 16'd1;
         xfer_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ca_q   <= {32'h0, bus.dq_i};
               cnt_q  <= CntW'(1);
               hi_q   <= 1'b1;
               xfer_q <= 1'b0;
            end
            S_CA: begin
               ca_q  <= {ca_q[31:0], bus.dq_i};
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(5)) begin
                  is_rd_q  <= ca_w[47];
                  is_reg_q <= ca_w[46];
                  lin_q    <= ca_w[45];
                  addr_q   <= {ca_w[16 +: AddrW-3], ca_w[2:0]};
                  cnt_q    <= CntW'(Lat - 1);
               end
            end
            S_LAT: cnt_q <= cnt_q - CntW'(1);
            S_WRITE, S_READ: begin
               hi_q   <= !hi_q;
               xfer_q <= 1'b1;
               if (!hi_q) addr_q <= addr_nxt;
            end
            S_REGW: begin
               // Only the first two bytes form CR0; later bytes fall through.
               if (!xfer_q) begin
                  if (hi_q) begin
                     cr0_hi_q <= bus.dq_i;
                     hi_q     <= 1'b0;
                  end else begin
                     cr0_q  <= {cr0_hi_q, bus.dq_i};
                     xfer_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Backing store is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !bus.cs_ni && state_q == S_WRITE && !bus.rwds_i) begin
         if (hi_q) mem[addr_q][15:8] <= bus.dq_i;
         else      mem[addr_q][7:0]  <= bus.dq_i;
      end
   end

endmodule

// File: tb/tb_hyperbus_dev_model.sv
// Bench for hyperbus_dev_model: one device with doubled latency (L=12) and one with
// single latency (L=6) share a stimulus stream; a byte-level model predicts both.
module tb_hyperbus_dev_model;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cr0_0, cr0_1, txn_0, txn_1;

   hyperbus_if bus0 ();
   hyperbus_if bus1 ();

   assign bus1.cs_ni  = bus0.cs_ni;
   assign bus1.dq_i   = bus0.dq_i;
   assign bus1.rwds_i = bus0.rwds_i;

   hyperbus_dev_model dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0), .cr0_o(cr0_0), .txn_cnt_o(txn_0));
   hyperbus_dev_model #(.DoubleLatency(0)) dut1 (
      .clk_i(clk), .rst_i(rst), .bus(bus1), .cr0_o(cr0_1), .txn_cnt_o(txn_1));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int lat [2] = '{12, 6};

   // Reference model state
   bit   [7:0]  m_mem   [2][8192];
   bit          m_known [2][8192];
   logic [15:0] m_cr0   [2];
   logic [15:0] m_txn   [2];

   // Stimulus by cycle number, observations and expectations by cycle number
   logic [7:0]  st_dq   [80];
   logic        st_mask [80];
   logic [7:0]  o_dq    [2][80];
   logic        o_dqoe  [2][80];
   logic        o_rwds  [2][80];
   logic        o_rwoe  [2][80];
   logic [15:0] o_cr0   [2][80];
   logic [15:0] o_txn   [2][80];
   logic [7:0]  e_dq    [2][80];
   logic        e_rw    [2][80];
   bit          e_chk   [2][80];
   bit          e_rd    [2][80];

   task automatic sample(input int c);
      o_dq[0][c] = bus0.dq_o;    o_dq[1][c] = bus1.dq_o;
      o_dqoe[0][c] = bus0.dq_oe_o; o_dqoe[1][c] = bus1.dq_oe_o;
      o_rwds[0][c] = bus0.rwds_o;  o_rwds[1][c] = bus1.rwds_o;
      o_rwoe[0][c] = bus0.rwds_oe_o; o_rwoe[1][c] = bus1.rwds_oe_o;
      o_cr0[0][c] = cr0_0; o_cr0[1][c] = cr0_1;
      o_txn[0][c] = txn_0; o_txn[1][c] = txn_1;
   endtask

   task automatic fill_rand();
      for (int c = 0; c < 80; c++) begin
         st_dq[c]   = 8'($urandom);
         st_mask[c] = 1'b0;
      end
   endtask

   // Drives one chip-select window of n cycles, then predicts both devices' behaviour.
   task automatic run_txn(input bit rd, input bit rg, input bit lin, input int word, input int n);
      logic [47:0] ca;
      int i, w, idx;
      ca = {rd, rg, lin, 20'($urandom), 9'(word >> 3), 13'($urandom), 3'(word)};
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         bus0.cs_ni  = 1'b0;
         bus0.dq_i   = (c < 6) ? ca[47-8*c -: 8] : st_dq[c];
         bus0.rwds_i = (c < 6) ? 1'b0 : st_mask[c];
         @(negedge clk); sample(c);
      end
      @(posedge clk); #1;
      bus0.cs_ni = 1'b1; bus0.dq_i = 8'h00; bus0.rwds_i = 1'b0;
      @(negedge clk); sample(n);
      @(posedge clk); #1;
      @(negedge clk); sample(n + 1);
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c <= n; c++) begin
            e_chk[k][c] = 1'b0; e_rd[k][c] = 1'b0; e_rw[k][c] = 1'b0; e_dq[k][c] = 8'h00;
         end
         if (rg && !rd) begin
            if (n >= 8) begin
               m_cr0[k] = {st_dq[6], st_dq[7]};
               m_txn[k] = m_txn[k] + 16'd1;
            end
         end else begin
            for (int c = 6 + lat[k]; c < n; c++) begin
               i   = c - 6 - lat[k];
               w   = lin ? (word + i / 2) % 4096 : ((word & ~15) | ((word + i / 2) & 15));
               idx = w * 2 + (i % 2);
               if (rd) begin
                  e_rd[k][c] = 1'b1;
                  e_rw[k][c] = (i % 2 == 0);
                  if (rg) begin
                     e_dq[k][c] = (i % 2 == 0) ? 8'h0c : 8'h81; e_chk[k][c] = 1'b1;
                  end else if (m_known[k][idx]) begin
                     e_dq[k][c] = m_mem[k][idx]; e_chk[k][c] = 1'b1;
                  end
               end else if (!st_mask[c]) begin
                  m_mem[k][idx] = st_dq[c]; m_known[k][idx] = 1'b1;
               end
            end
            if (n > 6 + lat[k]) m_txn[k] = m_txn[k] + 16'd1;
         end
      end
   endtask

   task automatic test_reset();
      bus0.cs_ni = 1'b1; bus0.dq_i = 8'h00; bus0.rwds_i = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); sample(0);
      for (int k = 0; k < 2; k++) begin
         m_cr0[k] = 16'h8f1f; m_txn[k] = 16'h0000;
         checks++;
         if ({o_dq[k][0], o_dqoe[k][0], o_rwds[k][0], o_rwoe[k][0]} !== 11'h0) begin
            failures++;
            $display("FAIL reset_outputs dut%0d got dq=%h oe=%b rwds=%b rwoe=%b want all 0",
                     k, o_dq[k][0], o_dqoe[k][0], o_rwds[k][0], o_rwoe[k][0]);
         end
         checks++;
         if (o_cr0[k][0] !== 16'h8f1f || o_txn[k][0] !== 16'h0) begin
            failures++;
            $display("FAIL reset_regs dut%0d got cr0=%h txn=%0d want cr0=8f1f txn=0",
                     k, o_cr0[k][0], o_txn[k][0]);
         end
      end
   endtask

   task automatic test_linear();
      int n;
      logic [7:0] want [4];
      want = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      fill_rand();
      for (int i = 0; i < 4; i++) st_dq[18 + i] = want[i];
      run_txn(1'b0, 1'b0, 1'b1, 16'h10, 22);
      fill_rand();
      n = 22;
      run_txn(1'b1, 1'b0, 1'b1, 16'h10, n);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (o_dq[0][18 + i] !== want[i] || o_dqoe[0][18 + i] !== 1'b1) begin
            failures++;
            $display("FAIL linear_read byte%0d got %h oe=%b want %h oe=1", i, o_dq[0][18 + i],
                     o_dqoe[0][18 + i], want[i]);
         end
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_dqoe[k][5 + lat[k]] !== 1'b0 || o_dqoe[k][6 + lat[k]] !== 1'b1) begin
            failures++;
            $display("FAIL first_byte_cycle dut%0d oe@%0d=%b oe@%0d=%b want 0,1", k, 5 + lat[k],
                     o_dqoe[k][5 + lat[k]], 6 + lat[k], o_dqoe[k][6 + lat[k]]);
         end
         for (int c = 1; c <= 5; c++) begin
            checks++;
            if (o_rwoe[k][c] !== 1'b1 || o_rwds[k][c] !== (k == 0)) begin
               failures++;
               $display("FAIL ca_rwds dut%0d cycle %0d got oe=%b rwds=%b want oe=1 rwds=%b", k, c,
                        o_rwoe[k][c], o_rwds[k][c], k == 0);
            end
         end
         for (int c = 0; c <= n; c++) begin
            checks++;
            if (o_dqoe[k][c] !== e_rd[k][c] || (e_chk[k][c] &&
                {o_dq[k][c], o_rwds[k][c]} !== {e_dq[k][c], e_rw[k][c]})) begin
               failures++;
               $display("FAIL linear_model dut%0d cycle %0d got dq=%h rwds=%b oe=%b want dq=%h rwds=%b oe=%b",
                        k, c, o_dq[k][c], o_rwds[k][c], o_dqoe[k][c], e_dq[k][c], e_rw[k][c], e_rd[k][c]);
            end
         end
         checks++;
         if (o_txn[k][n + 1] !== m_txn[k]) begin
            failures++;
            $display("FAIL linear_txn dut%0d got %0d want %0d", k, o_txn[k][n + 1], m_txn[k]);
         end
      end
   endtask

   task automatic test_wrap();
      bit [1:0] lin_rd;
      int start [2];
      start = '{16'h1F, 4095};
      fill_rand();
      run_txn(1'b0, 1'b0, 1'b0, 16'h10, 50);
      fill_rand();
      run_txn(1'b0, 1'b0, 1'b1, 4095, 22);
      lin_rd = 2'b10;
      for (int t = 0; t < 2; t++) begin
         fill_rand();
         run_txn(1'b1, 1'b0, lin_rd[t], start[t], 24);
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c <= 24; c++) begin
               checks++;
               if (o_dqoe[k][c] !== e_rd[k][c] || (e_chk[k][c] &&
                   {o_dq[k][c], o_rwds[k][c]} !== {e_dq[k][c], e_rw[k][c]})) begin
                  failures++;
                  $display("FAIL wrap_read%0d dut%0d cycle %0d got dq=%h rwds=%b oe=%b want dq=%h rwds=%b oe=%b",
                           t, k, c, o_dq[k][c], o_rwds[k][c], o_dqoe[k][c], e_dq[k][c], e_rw[k][c], e_rd[k][c]);
               end
            end
         end
      end
   endtask

   task automatic test_masked();
      fill_rand();
      st_dq[18] = 8'hFF; st_dq[19] = 8'hFF;
      run_txn(1'b0, 1'b0, 1'b1, 16'h40, 20);
      fill_rand();
      st_dq[18] = 8'h11; st_dq[19] = 8'h22; st_mask[19] = 1'b1;
      run_txn(1'b0, 1'b0, 1'b1, 16'h40, 20);
      fill_rand();
      run_txn(1'b1, 1'b0, 1'b1, 16'h40, 20);
      checks++;
      if ({o_dq[0][18], o_dq[0][19]} !== 16'h11FF) begin
         failures++;
         $display("FAIL masked_word got %h%h want 11ff", o_dq[0][18], o_dq[0][19]);
      end
      checks++;
      if (o_dq[1][12] !== e_dq[1][12] || e_chk[1][12] !== 1'b1) begin
         failures++;
         $display("FAIL masked_dut1 got %h want %h", o_dq[1][12], e_dq[1][12]);
      end
   endtask

   task automatic test_regs();
      logic [15:0] old_cr0 [2];
      logic [15:0] old_txn [2];
      old_cr0 = m_cr0; old_txn = m_txn;
      fill_rand();
      st_dq[6] = 8'h8F; st_dq[7] = 8'h17;
      run_txn(1'b0, 1'b1, 1'b1, 0, 10);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_cr0[k][7] !== old_cr0[k] || o_cr0[k][8] !== 16'h8f17 || o_cr0[k][10] !== 16'h8f17) begin
            failures++;
            $display("FAIL cr0_write dut%0d got c7=%h c8=%h c10=%h want %h,8f17,8f17", k,
                     o_cr0[k][7], o_cr0[k][8], o_cr0[k][10], old_cr0[k]);
         end
         checks++;
         if (o_txn[k][11] !== old_txn[k] + 16'd1) begin
            failures++;
            $display("FAIL regw_txn dut%0d got %0d want %0d", k, o_txn[k][11], old_txn[k] + 16'd1);
         end
      end
      fill_rand();
      run_txn(1'b1, 1'b1, 1'b1, 16'h33, 22);
      checks++;
      if ({o_dq[0][18], o_dq[0][19], o_dq[0][20], o_dq[0][21]} !== 32'h0c810c81) begin
         failures++;
         $display("FAIL id_read got %h %h %h %h want 0c 81 0c 81", o_dq[0][18], o_dq[0][19],
                  o_dq[0][20], o_dq[0][21]);
      end
      checks++;
      if ({o_dq[1][12], o_dq[1][13]} !== 16'h0c81) begin
         failures++;
         $display("FAIL id_read_dut1 got %h %h want 0c 81", o_dq[1][12], o_dq[1][13]);
      end
   endtask

   task automatic test_abort();
      logic [15:0] old_txn [2];
      old_txn = m_txn;
      fill_rand();
      run_txn(1'b0, 1'b0, 1'b1, 16'h40, 3);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_txn[k][4] !== old_txn[k]) begin
            failures++;
            $display("FAIL abort_txn dut%0d got %0d want %0d", k, o_txn[k][4], old_txn[k]);
         end
      end
      fill_rand();
      run_txn(1'b1, 1'b0, 1'b1, 16'h40, 22);
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c <= 22; c++) begin
            checks++;
            if (o_dqoe[k][c] !== e_rd[k][c] || (e_chk[k][c] && o_dq[k][c] !== e_dq[k][c])) begin
               failures++;
               $display("FAIL after_abort dut%0d cycle %0d got dq=%h oe=%b want dq=%h oe=%b",
                        k, c, o_dq[k][c], o_dqoe[k][c], e_dq[k][c], e_rd[k][c]);
            end
         end
         checks++;
         if (o_txn[k][23] !== m_txn[k]) begin
            failures++;
            $display("FAIL after_abort_txn dut%0d got %0d want %0d", k, o_txn[k][23], m_txn[k]);
         end
      end
   endtask

   task automatic test_random();
      int base, n;
      for (int it = 0; it < 8; it++) begin
         base = 16'h100 + int'($urandom_range(0, 63));
         fill_rand();
         for (int c = 0; c < 80; c++) st_mask[c] = ($urandom_range(0, 3) == 0);
         run_txn(1'b0, 1'b0, 1'($urandom), base, 18 + int'($urandom_range(1, 30)));
         fill_rand();
         n = 18 + int'($urandom_range(1, 30));
         run_txn(1'b1, 1'b0, 1'($urandom), base, n);
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c <= n; c++) begin
               checks++;
               if (o_dqoe[k][c] !== e_rd[k][c] || (e_chk[k][c] &&
                   {o_dq[k][c], o_rwds[k][c]} !== {e_dq[k][c], e_rw[k][c]})) begin
                  failures++;
                  $display("FAIL random%0d dut%0d cycle %0d got dq=%h rwds=%b oe=%b want dq=%h rwds=%b oe=%b",
                           it, k, c, o_dq[k][c], o_rwds[k][c], o_dqoe[k][c], e_dq[k][c], e_rw[k][c], e_rd[k][c]);
               end
            end
            checks++;
            if (o_txn[k][n + 1] !== m_txn[k]) begin
               failures++;
               $display("FAIL random%0d_txn dut%0d got %0d want %0d", it, k, o_txn[k][n + 1], m_txn[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      logic [47:0] ca;
      ca = {3'b101, 20'h0, 9'(16'h10 >> 3), 13'h0, 3'(16'h10)};
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         bus0.cs_ni = 1'b0;
         bus0.dq_i  = (c < 6) ? ca[47-8*c -: 8] : 8'h00;
         rst        = (c == 19);
         @(negedge clk); sample(c);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); sample(20);
      for (int k = 0; k < 2; k++) begin
         m_cr0[k] = 16'h8f1f; m_txn[k] = 16'h0;
         checks++;
         if (o_dqoe[k][19] !== 1'b1 || {o_dq[k][20], o_dqoe[k][20], o_rwds[k][20], o_rwoe[k][20]} !== 11'h0) begin
            failures++;
            $display("FAIL reset_mid_read dut%0d oe_before=%b after dq=%h oe=%b rwds=%b rwoe=%b want 1 then 0",
                     k, o_dqoe[k][19], o_dq[k][20], o_dqoe[k][20], o_rwds[k][20], o_rwoe[k][20]);
         end
         checks++;
         if (o_cr0[k][20] !== 16'h8f1f || o_txn[k][20] !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_read_regs dut%0d got cr0=%h txn=%0d want 8f1f 0", k, o_cr0[k][20], o_txn[k][20]);
         end
      end
      @(posedge clk); #1 bus0.cs_ni = 1'b1;
      repeat (2) @(posedge clk);
      fill_rand();
      run_txn(1'b1, 1'b0, 1'b1, 16'h40, 20);
      checks++;
      if ({o_dq[0][18], o_dq[0][19]} !== 16'h11FF) begin
         failures++;
         $display("FAIL mem_kept_over_reset got %h%h want 11ff", o_dq[0][18], o_dq[0][19]);
      end
   endtask

   initial begin
      bus0.cs_ni = 1'b1; bus0.dq_i = 8'h00; bus0.rwds_i = 1'b0;
      test_reset();
      test_linear();
      test_wrap();
      test_masked();
      test_regs();
      test_abort();
      test_random();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
